mul_seq: RTL

//  Iterative RV32M multiply sequencer: accepts one MUL/MULH/MULHSU/MULHU op via

---
 rtl/mul_seq.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mul_seq.sv
// Iterative RV32M multiply unit (MUL/MULH/MULHSU/MULHU): shift-add over XLEN/STEP
// cycles on operand magnitudes, one sign-fix cycle, result held until consumed.
module mul_seq #(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] y,
    output logic            busy
);

    localparam int ITERS = XLEN / STEP;
    localparam int CW    = $clog2(ITERS) + 1;
    localparam int PW    = 2 * XLEN;
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] ma_q, ma_d;
    logic [XLEN-1:0] mb_q, mb_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic            neg_q, neg_d;
    logic            lo_q, lo_d;
    logic [XLEN-1:0] y_q, y_d;

    logic            a_signed, b_signed, sa, sb;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN+STEP-1:0] partial;
    logic [XLEN+STEP:0]   sum;
    logic [PW-1:0]   step_prod, fixed;

    // funct3[2] distinguishes div ops, which the decoder never routes here
    logic unused_funct3;
    assign unused_funct3 = funct3[2];

    assign a_signed = (funct3[1:0] == 2'b01) || (funct3[1:0] == 2'b10);
    assign b_signed = (funct3[1:0] == 2'b01);
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];
    assign a_mag    = sa ? -a : a;
    assign b_mag    = sb ? -b : b;

    // Add |a| * next STEP multiplier bits into the upper half, then shift right by STEP
    assign partial   = {{STEP{1'b0}}, ma_q} * {{XLEN{1'b0}}, mb_q[STEP-1:0]};
    assign sum       = {{(STEP+1){1'b0}}, prod_q[PW-1:XLEN]} + {1'b0, partial};
    assign step_prod = PW'({sum, prod_q[XLEN-1:0]} >> STEP);
    assign fixed     = neg_q ? -prod_q : prod_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        prod_d  = prod_q;
        neg_d   = neg_q;
        lo_d    = lo_q;
        y_d     = y_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid && !flush) begin
                    ma_d    = a_mag;
                    mb_d    = b_mag;
                    prod_d  = '0;
                    neg_d   = sa ^ sb;
                    lo_d    = (funct3[1:0] == 2'b00);
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    prod_d = step_prod;
                    mb_d   = mb_q >> STEP;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    y_d     = lo_q ? fixed[XLEN-1:0] : fixed[PW-1:XLEN];
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (flush || resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ma_q    <= '0;
            mb_q    <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            lo_q    <= 1'b0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            prod_q  <= prod_d;
            neg_q   <= neg_d;
            lo_q    <= lo_d;
            y_q     <= y_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_DONE);
    assign busy       = (state_q != S_IDLE);
    assign y          = y_q;

endmodule
